// File: rtl/ca_gen.sv
// ca_gen: 1-D cellular-automaton hypervector generator (rules 90/150/30).
// Emits n_steps successive generations of a seed over a valid/ready stream.
module ca_gen #(
    parameter int DIM    = 1024,
    parameter int STEP_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              seed_valid,
    output logic              seed_ready,
    input  logic [DIM-1:0]    seed,
    input  logic [1:0]        rule_sel,
    input  logic              bnd_null,
    input  logic [STEP_W-1:0] n_steps,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DIM-1:0]    vec_out,
    output logic              out_last,
    output logic              busy
);
    typedef enum logic {IDLE, GEN} state_t;

    state_t            st_q, st_d;
    logic [DIM-1:0]    vec_q, vec_d;
    logic [STEP_W-1:0] cnt_q, cnt_d;
    logic [1:0]        rule_q, rule_d;
    logic              bnd_q, bnd_d;
    logic              seed_hs, out_hs;

    // Whole-vector neighbour shifts; a null boundary injects zeros at the ends.
    function automatic logic [DIM-1:0] ca_step(input logic [DIM-1:0] v, input logic [1:0] rule,
                                               input logic bnd);
        logic [DIM-1:0] l, r;
        l = {v[DIM-2:0], v[DIM-1] & ~bnd};
        r = {v[0] & ~bnd, v[DIM-1:1]};
        return rule == 2'd1 ? l ^ v ^ r : rule == 2'd2 ? l ^ (v | r) : l ^ r;
    endfunction

    assign seed_ready = rst_n && en && st_q == IDLE;
    assign out_valid  = st_q == GEN;
    assign busy       = st_q == GEN;
    assign out_last   = st_q == GEN && cnt_q == STEP_W'(1);
    assign vec_out    = st_q == GEN ? vec_q : '0;
    assign seed_hs    = en && seed_valid && seed_ready;
    assign out_hs     = en && out_valid && out_ready;

    always_comb begin
        st_d   = st_q;
        vec_d  = vec_q;
        cnt_d  = cnt_q;
        rule_d = rule_q;
        bnd_d  = bnd_q;
        if (seed_hs && n_steps != '0) begin
            st_d   = GEN;
            vec_d  = ca_step(seed, rule_sel, bnd_null);
            cnt_d  = n_steps;
            rule_d = rule_sel;
            bnd_d  = bnd_null;
        end else if (out_hs) begin
            if (cnt_q == STEP_W'(1)) begin
                st_d  = IDLE;
                vec_d = '0;
                cnt_d = '0;
            end else begin
                vec_d = ca_step(vec_q, rule_q, bnd_q);
                cnt_d = cnt_q - STEP_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q   <= IDLE;
            vec_q  <= '0;
            cnt_q  <= '0;
            rule_q <= '0;
            bnd_q  <= 1'b0;
        end else begin
            st_q   <= st_d;
            vec_q  <= vec_d;
            cnt_q  <= cnt_d;
            rule_q <= rule_d;
            bnd_q  <= bnd_d;
        end
    end
endmodule

// File: tb/tb_ca_gen.sv
// tb_ca_gen: table-driven and randomized checks of ca_gen (DIM=8, STEP_W=4)
// against a per-cell reference automaton.
module tb_ca_gen;
    localparam int DIM    = 8;
    localparam int STEP_W = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b1;
    logic              seed_valid = 1'b0;
    logic              seed_ready;
    logic [DIM-1:0]    seed = '0;
    logic [1:0]        rule_sel = '0;
    logic              bnd_null = 1'b0;
    logic [STEP_W-1:0] n_steps = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DIM-1:0]    vec_out;
    logic              out_last;
    logic              busy;

    int total = 0;
    int bad   = 0;

    ca_gen #(.DIM(DIM), .STEP_W(STEP_W)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .seed_valid(seed_valid), .seed_ready(seed_ready),
        .seed(seed), .rule_sel(rule_sel), .bnd_null(bnd_null), .n_steps(n_steps),
        .out_valid(out_valid), .out_ready(out_ready), .vec_out(vec_out),
        .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] s;
        logic [1:0] r;
        logic       b;
        logic [3:0] n;
        int         stall;
        logic [7:0] e0;
        logic [7:0] e1;
        logic [7:0] e2;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ref_step(input logic [7:0] v, input logic [1:0] r, input logic b);
        logic [7:0] o;
        for (int i = 0; i < DIM; i++) begin
            logic lb, cb, rb;
            lb = (b && i == 0) ? 1'b0 : v[(i + DIM - 1) % DIM];
            cb = v[i];
            rb = (b && i == DIM - 1) ? 1'b0 : v[(i + 1) % DIM];
            o[i] = r == 2'd2 ? lb ^ (cb | rb) : r == 2'd1 ? lb ^ cb ^ rb : lb ^ rb;
        end
        return o;
    endfunction

    logic [7:0] got[$];

    task automatic run_req(input logic [7:0] s, input logic [1:0] r, input logic b,
                           input logic [3:0] n, input bit rnd, input int stall);
        logic [7:0] m;
        int k, t;
        got.delete();
        @(negedge clk);
        en = 1'b1; seed = s; rule_sel = r; bnd_null = b; n_steps = n;
        seed_valid = 1'b1; out_ready = 1'b0;
        #1 chk("seed_ready", 32'(seed_ready), 32'd1);
        @(posedge clk);
        m = ref_step(s, r, b);
        k = 0;
        t = 0;
        if (n == 0) begin
            @(negedge clk);
            seed_valid = 1'b0;
            #1 chk("zero_no_valid", 32'(out_valid), 32'd0);
            chk("zero_ready", 32'(seed_ready), 32'd1);
        end else begin
            while (k < int'(n) && t < 400) begin
                @(negedge clk);
                seed_valid = 1'b0;
                seed = 8'($urandom);
                if (t < stall) begin
                    en = 1'b1; out_ready = 1'b0; rule_sel = ~r; bnd_null = ~b;
                end else if (rnd) begin
                    en = $urandom_range(0, 3) != 0;
                    out_ready = 1'($urandom);
                    rule_sel = 2'($urandom);
                    bnd_null = 1'($urandom);
                end else begin
                    en = 1'b1; out_ready = 1'b1;
                end
                #1 chk("gen_valid", 32'(out_valid), 32'd1);
                chk("gen_busy", 32'(busy), 32'd1);
                chk("gen_vec", 32'(vec_out), 32'(m));
                chk("gen_last", 32'(out_last), 32'(k == int'(n) - 1));
                if (en && out_ready) begin
                    got.push_back(vec_out);
                    k++;
                    m = ref_step(m, r, b);
                end
                t++;
                @(posedge clk);
            end
            chk("req_done", 32'(k), 32'(n));
            @(negedge clk);
            en = 1'b1; out_ready = 1'b0;
            #1 chk("end_valid", 32'(out_valid), 32'd0);
            chk("end_busy", 32'(busy), 32'd0);
            chk("end_last", 32'(out_last), 32'd0);
            chk("end_vec", 32'(vec_out), 32'd0);
            chk("end_ready", 32'(seed_ready), 32'd1);
        end
    endtask

    initial begin
        vec_t tbl[6];
        tbl[0] = '{8'h01, 2'd0, 1'b0, 4'd2, 0, 8'h82, 8'h44, 8'h00};
        tbl[1] = '{8'h01, 2'd1, 1'b0, 4'd1, 0, 8'h83, 8'h00, 8'h00};
        tbl[2] = '{8'h01, 2'd2, 1'b0, 4'd1, 0, 8'h83, 8'h00, 8'h00};
        tbl[3] = '{8'h01, 2'd0, 1'b1, 4'd1, 0, 8'h02, 8'h00, 8'h00};
        tbl[4] = '{8'h01, 2'd0, 1'b0, 4'd3, 5, 8'h82, 8'h44, 8'hAA};
        tbl[5] = '{8'h01, 2'd3, 1'b0, 4'd2, 0, 8'h82, 8'h44, 8'h00};

        #2;
        chk("rst_ready", 32'(seed_ready), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_vec", 32'(vec_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_req(tbl[i].s, tbl[i].r, tbl[i].b, tbl[i].n, 1'b0, tbl[i].stall);
            chk("tbl_cnt", 32'(got.size()), 32'(tbl[i].n));
            if (got.size() > 0) chk("tbl_v0", 32'(got[0]), 32'(tbl[i].e0));
            if (got.size() > 1) chk("tbl_v1", 32'(got[1]), 32'(tbl[i].e1));
            if (got.size() > 2) chk("tbl_v2", 32'(got[2]), 32'(tbl[i].e2));
        end

        run_req(8'h5A, 2'd1, 1'b0, 4'd0, 1'b0, 0);

        // A seed offered with en low must not be taken.
        @(negedge clk);
        en = 1'b0; seed_valid = 1'b1; seed = 8'h01; n_steps = 4'd3;
        #1 chk("en0_ready", 32'(seed_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        seed_valid = 1'b0;
        #1 chk("en0_valid", 32'(out_valid), 32'd0);
        en = 1'b1;

        // Reset in the middle of a 4-step request.
        @(negedge clk);
        seed = 8'h01; rule_sel = 2'd0; bnd_null = 1'b0; n_steps = 4'd4; seed_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        seed_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        #1 chk("mid_vec", 32'(vec_out), 32'h44);
        rst_n = 1'b0;
        #1 chk("mid_rst_vec", 32'(vec_out), 32'd0);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_last", 32'(out_last), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ready", 32'(seed_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("post_rst_ready", 32'(seed_ready), 32'd1);

        run_req(8'hC3, 2'd2, 1'b1, 4'd15, 1'b1, 0);
        for (int i = 0; i < 30; i++)
            run_req(8'($urandom), 2'($urandom), 1'($urandom), 4'($urandom), 1'b1,
                    $urandom_range(0, 2));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
